// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode/execute stage registers:
// occupancy encoding and the NOP payloads each stage inserts as a bubble.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_t;

   // Control bundle carried between decode and execute.
   typedef struct packed {
      logic       reg_write;
      logic       mem_access;
      logic       mem_write;
      logic       branch;
      logic [3:0] alu_op;
      logic [4:0] rd;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   localparam ctrl_t CTRL_NOP = '{
      reg_write:  1'b0,
      mem_access: 1'b0,
      mem_write:  1'b0,
      branch:     1'b0,
      alu_op:     4'd0,
      rd:         5'd0
   };

   // addi x0, x0, 0 -- the canonical fetch-stage bubble.
   localparam logic [31:0] FETCH_BUBBLE  = 32'h0000_0013;
   localparam logic [31:0] DECODE_BUBBLE = 32'h0000_0000;
   localparam logic [CTRL_W-1:0] EXEC_BUBBLE = CTRL_NOP;

   function automatic logic is_nop_ctrl(input ctrl_t c);
      return !c.reg_write && !c.mem_access;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream between two pipeline stages, seen from both sides of a stage register.
// A beat transfers on a rising edge where valid and ready are both high; valid, once raised,
// is not required to hold, and ready may depend on valid only through the stage itself.
interface pipe_stage_reg_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter, cleared only by reset; reusable by any stage for perf monitoring.
module pipe_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] STEP = W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + STEP;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake, optional two-entry skid buffer,
// flush-to-bubble and a starvation counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter bit               SKID   = 1'b1,
   parameter int               CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   pipe_stage_reg_if.slave   bus,
   output logic [CNT_W-1:0]  bubble_cnt,
   output pipe_state_t       state
);

   logic             in_ready_w;
   logic             out_valid_w;
   logic [WIDTH-1:0] out_data_w;

   if (SKID) begin : g_skid
      pipe_state_t      st_q;
      logic [WIDTH-1:0] main_q;
      logic [WIDTH-1:0] skid_q;
      logic             in_ready_q;
      logic             out_valid_q;
      logic             accept;
      logic             pop;

      assign accept = bus.in_valid & in_ready_q & ~flush;
      assign pop    = out_valid_q & bus.out_ready & ~flush;

      // in_ready is a register so out_ready never reaches upstream combinationally.
      always_ff @(posedge clk) begin
         if (rst || flush) begin
            st_q        <= EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
         end else begin
            case (st_q)
               EMPTY: begin
                  if (accept) begin
                     st_q        <= ONE;
                     main_q      <= bus.in_data;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b1;
                  end
               end
               ONE: begin
                  if (accept && !pop) begin
                     st_q       <= TWO;
                     skid_q     <= bus.in_data;
                     in_ready_q <= 1'b0;
                  end else if (accept && pop) begin
                     main_q <= bus.in_data;
                  end else if (pop) begin
                     st_q        <= EMPTY;
                     main_q      <= BUBBLE;
                     out_valid_q <= 1'b0;
                  end
               end
               TWO: begin
                  if (pop) begin
                     st_q       <= ONE;
                     main_q     <= skid_q;
                     skid_q     <= BUBBLE;
                     in_ready_q <= 1'b1;
                  end
               end
               default: begin
                  st_q        <= EMPTY;
                  main_q      <= BUBBLE;
                  skid_q      <= BUBBLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            endcase
         end
      end

      assign in_ready_w  = in_ready_q;
      assign out_valid_w = out_valid_q;
      assign out_data_w  = main_q;
      assign state       = st_q;
   end else begin : g_single
      pipe_state_t      st_q;
      logic [WIDTH-1:0] main_q;
      logic             out_valid_q;
      logic             accept;
      logic             pop;

      assign in_ready_w = (~out_valid_q | bus.out_ready) & ~flush;
      assign accept     = bus.in_valid & in_ready_w;
      assign pop        = out_valid_q & bus.out_ready & ~flush;

      always_ff @(posedge clk) begin
         if (rst || flush) begin
            st_q        <= EMPTY;
            main_q      <= BUBBLE;
            out_valid_q <= 1'b0;
         end else if (accept) begin
            st_q        <= ONE;
            main_q      <= bus.in_data;
            out_valid_q <= 1'b1;
         end else if (pop) begin
            st_q        <= EMPTY;
            main_q      <= BUBBLE;
            out_valid_q <= 1'b0;
         end
      end

      assign out_valid_w = out_valid_q;
      assign out_data_w  = main_q;
      assign state       = st_q;
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.out_data  = out_data_w;

   pipe_sat_counter #(
      .W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.out_ready & ~out_valid_w & ~flush),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and single-register variants plus a narrow-counter instance,
// checked by per-instance expected queues and directed checks.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam logic [7:0] BUB = 8'hAA;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_a = 1'b0;
   logic        flush_b = 1'b0;
   logic        flush_c = 1'b0;
   logic [15:0] cnt_a;
   logic [15:0] cnt_b;
   logic [2:0]  cnt_c;
   logic [15:0] snap_a;
   logic [15:0] snap_b;
   pipe_state_t st_a;
   pipe_state_t st_b;
   pipe_state_t st_c;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_a_q[$];
   logic [7:0] exp_b_q[$];

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.WIDTH(8)) if_a ();
   pipe_stage_reg_if #(.WIDTH(8)) if_b ();
   pipe_stage_reg_if #(.WIDTH(8)) if_c ();

   pipe_stage_reg #(.WIDTH(8), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .flush(flush_a), .bus(if_a), .bubble_cnt(cnt_a), .state(st_a)
   );
   pipe_stage_reg #(.WIDTH(8), .BUBBLE(BUB), .SKID(1'b0), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .flush(flush_b), .bus(if_b), .bubble_cnt(cnt_b), .state(st_b)
   );
   pipe_stage_reg #(.WIDTH(8), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(3)) dut_c (
      .clk(clk), .rst(rst), .flush(flush_c), .bus(if_c), .bubble_cnt(cnt_c), .state(st_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
      if_a.in_valid  = v;
      if_a.in_data   = d;
      if_a.out_ready = ordy;
      flush_a        = fl;
   endtask

   task automatic drive_b(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
      if_b.in_valid  = v;
      if_b.in_data   = d;
      if_b.out_ready = ordy;
      flush_b        = fl;
   endtask

   // Scoreboards: inputs are stable at the falling edge, so the handshakes seen here
   // are exactly the transfers of the next rising edge.
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst || flush_a) begin
         exp_a_q.delete();
      end else begin
         if (if_a.out_valid && if_a.out_ready) begin
            check("a_sb_nonempty", 32'(exp_a_q.size() > 0), 1);
            if (exp_a_q.size() > 0) begin
               e = exp_a_q.pop_front();
               check("a_sb_data", 32'(if_a.out_data), 32'(e));
            end
         end
         if (if_a.in_valid && if_a.in_ready) exp_a_q.push_back(if_a.in_data);
      end
      if (!rst && !if_a.out_valid) check("a_bubble_data", 32'(if_a.out_data), 32'(BUB));
   end

   always @(negedge clk) begin
      logic [7:0] e;
      if (rst || flush_b) begin
         exp_b_q.delete();
      end else begin
         if (if_b.out_valid && if_b.out_ready) begin
            check("b_sb_nonempty", 32'(exp_b_q.size() > 0), 1);
            if (exp_b_q.size() > 0) begin
               e = exp_b_q.pop_front();
               check("b_sb_data", 32'(if_b.out_data), 32'(e));
            end
         end
         if (if_b.in_valid && if_b.in_ready) exp_b_q.push_back(if_b.in_data);
      end
      if (!rst && !if_b.out_valid) check("b_bubble_data", 32'(if_b.out_data), 32'(BUB));
   end

   initial begin
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      drive_b(1'b0, 8'h00, 1'b1, 1'b0);
      if_c.in_valid  = 1'b0;
      if_c.in_data   = 8'h00;
      if_c.out_ready = 1'b1;

      // reset and idle
      rst = 1'b1;
      step();
      step();
      check("rst_a_out_valid", 32'(if_a.out_valid), 0);
      check("rst_a_out_data", 32'(if_a.out_data), 32'(BUB));
      check("rst_a_in_ready", 32'(if_a.in_ready), 1);
      check("rst_a_cnt", 32'(cnt_a), 0);
      check("rst_a_state", 32'(st_a), 32'(EMPTY));
      check("rst_b_out_valid", 32'(if_b.out_valid), 0);
      check("rst_b_in_ready", 32'(if_b.in_ready), 1);
      check("rst_b_out_data", 32'(if_b.out_data), 32'(BUB));
      check("rst_c_cnt", 32'(cnt_c), 0);
      rst = 1'b0;
      repeat (3) step();
      check("idle_a_cnt", 32'(cnt_a), 3);
      check("idle_b_cnt", 32'(cnt_b), 3);
      check("idle_c_cnt", 32'(cnt_c), 3);

      // saturation of the 3-bit counter after 10 starved cycles
      repeat (7) step();
      check("sat_c_cnt", 32'(cnt_c), 7);
      check("sat_a_cnt", 32'(cnt_a), 10);
      rst = 1'b1;
      step();
      check("sat_c_rst", 32'(cnt_c), 0);
      check("sat_a_rst", 32'(cnt_a), 0);
      rst = 1'b0;

      // streaming 01..10 back to back in both modes
      for (int i = 1; i <= 16; i++) begin
         drive_a(1'b1, 8'(i), 1'b1, 1'b0);
         drive_b(1'b1, 8'(i), 1'b1, 1'b0);
         step();
         if (i == 1) begin
            snap_a = cnt_a;
            snap_b = cnt_b;
         end
         check("stream_a_valid", 32'(if_a.out_valid), 1);
         check("stream_a_data", 32'(if_a.out_data), 32'(i));
         check("stream_b_valid", 32'(if_b.out_valid), 1);
         check("stream_b_data", 32'(if_b.out_data), 32'(i));
      end
      check("stream_a_cnt", 32'(cnt_a), 32'(snap_a));
      check("stream_b_cnt", 32'(cnt_b), 32'(snap_b));
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      drive_b(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check("stream_a_drain", 32'(if_a.out_valid), 0);
      check("stream_b_drain", 32'(if_b.out_valid), 0);

      // back-pressure into the skid entry
      drive_a(1'b1, 8'h01, 1'b1, 1'b0);
      step();
      check("bp_first", 32'(if_a.out_data), 32'h01);
      drive_a(1'b1, 8'h02, 1'b0, 1'b0);
      step();
      check("bp_hold1_data", 32'(if_a.out_data), 32'h01);
      check("bp_hold1_ready", 32'(if_a.in_ready), 0);
      check("bp_hold1_state", 32'(st_a), 32'(TWO));
      drive_a(1'b1, 8'h03, 1'b0, 1'b0);
      step();
      check("bp_hold2_data", 32'(if_a.out_data), 32'h01);
      check("bp_hold2_ready", 32'(if_a.in_ready), 0);
      drive_a(1'b1, 8'h03, 1'b1, 1'b0);
      step();
      check("bp_resume_data", 32'(if_a.out_data), 32'h02);
      check("bp_resume_ready", 32'(if_a.in_ready), 1);
      drive_a(1'b1, 8'h03, 1'b1, 1'b0);
      step();
      check("bp_last_data", 32'(if_a.out_data), 32'h03);
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check("bp_empty", 32'(if_a.out_valid), 0);

      // flush with both entries full and a beat offered
      drive_a(1'b1, 8'h05, 1'b0, 1'b0);
      step();
      drive_a(1'b1, 8'h06, 1'b0, 1'b0);
      step();
      check("fl_full_state", 32'(st_a), 32'(TWO));
      check("fl_full_head", 32'(if_a.out_data), 32'h05);
      drive_a(1'b1, 8'h07, 1'b1, 1'b1);
      step();
      check("fl_valid", 32'(if_a.out_valid), 0);
      check("fl_data", 32'(if_a.out_data), 32'(BUB));
      check("fl_state", 32'(st_a), 32'(EMPTY));
      check("fl_in_ready", 32'(if_a.in_ready), 1);
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (3) step();
      check("fl_no_07", 32'(if_a.out_valid), 0);

      // single-register mode: ready follows out_ready in the same cycle
      drive_b(1'b1, 8'h11, 1'b1, 1'b0);
      step();
      check("s0_load", 32'(if_b.out_data), 32'h11);
      drive_b(1'b1, 8'h22, 1'b0, 1'b0);
      #1 check("s0_ready_lo", 32'(if_b.in_ready), 0);
      step();
      check("s0_hold", 32'(if_b.out_data), 32'h11);
      drive_b(1'b1, 8'h22, 1'b1, 1'b0);
      #1 check("s0_ready_hi", 32'(if_b.in_ready), 1);
      step();
      check("s0_next", 32'(if_b.out_data), 32'h22);
      drive_b(1'b0, 8'h00, 1'b0, 1'b0);
      #1 check("s0_ready_lo2", 32'(if_b.in_ready), 0);
      step();
      check("s0_hold2", 32'(if_b.out_data), 32'h22);
      drive_b(1'b0, 8'h00, 1'b1, 1'b0);
      #1 check("s0_ready_hi2", 32'(if_b.in_ready), 1);
      step();
      check("s0_empty", 32'(if_b.out_valid), 0);
      drive_b(1'b0, 8'h00, 1'b1, 1'b1);
      #1 check("s0_ready_flush", 32'(if_b.in_ready), 0);
      step();
      drive_b(1'b0, 8'h00, 1'b1, 1'b0);

      // reset together with flush and a live transfer
      drive_a(1'b1, 8'h33, 1'b0, 1'b0);
      drive_b(1'b1, 8'h33, 1'b0, 1'b0);
      step();
      rst = 1'b1;
      drive_a(1'b1, 8'h44, 1'b1, 1'b1);
      drive_b(1'b1, 8'h44, 1'b1, 1'b1);
      step();
      rst = 1'b0;
      drive_a(1'b0, 8'h00, 1'b0, 1'b0);
      drive_b(1'b0, 8'h00, 1'b0, 1'b0);
      check("rstfl_a_valid", 32'(if_a.out_valid), 0);
      check("rstfl_a_cnt", 32'(cnt_a), 0);
      check("rstfl_b_valid", 32'(if_b.out_valid), 0);
      check("rstfl_b_cnt", 32'(cnt_b), 0);

      // random traffic, back-pressure and occasional flush
      repeat (400) begin
         drive_a(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
         drive_b(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
         step();
      end
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      drive_b(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (4) step();
      check("drain_a_queue", 32'(exp_a_q.size()), 0);
      check("drain_b_queue", 32'(exp_b_q.size()), 0);
      check("drain_a_valid", 32'(if_a.out_valid), 0);
      check("drain_b_valid", 32'(if_b.out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed-field, flush-only inter-stage registers between fetch, decode and execute. It carries an opaque `WIDTH`-bit payload (decoded fields and control bundle concatenated by the caller) with a valid/ready handshake. It has an optional two-entry skid buffer so that back-pressure does not form a combinational path. Flush inserts a bubble whose payload is the parameter `BUBBLE`, and a saturating counter reports downstream starvation cycles for performance monitoring.

## Interface
- `WIDTH`, 32: payload width in bits, ≥1.
- `BUBBLE`, `{WIDTH{1'b0}}`: payload value presented whenever no valid entry is at the output.
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `CNT_W`, 16: width of `bubble_cnt`, ≥1.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all held entries and any input offered this cycle.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage accepts this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` is a valid entry.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  head payload; equals `BUBBLE` when `out_valid` = 0.
- `bubble_cnt`  out  CNT_W  saturating count of starvation cycles.

## Operation
- Definitions: accept = `in_valid & in_ready & !flush`; pop = `out_valid & out_ready & !flush`.
- SKID = 1: there are two storage entries, main (head) and skid. The state is EMPTY, ONE or TWO.
  - EMPTY: accept moves to ONE (main ← `in_data`).
  - ONE: accept with no pop moves to TWO (skid ← `in_data`). Accept with pop stays ONE (main ← `in_data`). Pop with no accept moves to EMPTY (main ← `BUBBLE`).
  - TWO: pop moves to ONE (main ← skid, skid ← `BUBBLE`). Accept cannot occur in TWO.
  - `in_ready` = (state != TWO). It is driven from a register, with no combinational path from `out_ready`.
- SKID = 0: one entry.
  - `in_ready` = `!out_valid | out_ready`, and is 0 while `flush` is high.
  - Accept loads main; pop with no accept loads `BUBBLE`.
- `out_valid` = (state != EMPTY). `out_data` = main. Order is strictly FIFO; no entry is duplicated or lost except by flush.
- Flush has priority over all other events. The next state is EMPTY, main and skid ← `BUBBLE`, and the input offered in the flush cycle is dropped. In SKID = 1, `in_ready` may be 1 during flush, but no transfer occurs.
- Stall is expressed only by `out_ready` = 0: the held entries and `out_data` stay unchanged.
- `bubble_cnt` increments by 1 in every cycle where `out_ready` & `!out_valid` & `!flush`, and saturates at 2^CNT_W−1. It is cleared only by `rst`.

## Timing
- Reset values: state EMPTY, main/skid = `BUBBLE`, `out_valid` 0, `out_data` `BUBBLE`, `bubble_cnt` 0. `in_ready` is 1 after reset (SKID = 1), or 1 because `!out_valid` (SKID = 0).
- Latency is 1 cycle: data accepted at edge N appears on `out_data` after edge N. There is no bypass path from input to output.
- Throughput is 1 transfer per cycle sustained when `out_ready` = 1, in both modes.
- SKID = 1: when `out_ready` drops, one more beat is absorbed, and `in_ready` falls the following cycle.
- Reset asserted mid-stream takes effect on the next edge and overrides flush and all transfers.
- Simultaneous flush and rst behaves as rst.

## Structure
- Shared package `pipe_pkg`:
  - state encoding `pipe_state_t` (EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2);
  - default `BUBBLE` constants per stage (e.g. a NOP bundle with `reg_write` = 0 and `mem_access` = 0).
- One sub-module, `pipe_sat_counter`, holds the CNT_W saturating counter so the other stages can reuse it.
- SKID selection is done with a generate block in the top; there is no further hierarchy.

## Test plan
- Reset and idle: WIDTH = 8, BUBBLE = 8'hAA, hold `rst` for 2 cycles with `out_ready` = 1 → `out_valid` 0, `out_data` 8'hAA, `in_ready` 1, `bubble_cnt` 0. Then release `rst` and wait 3 idle cycles → `bubble_cnt` = 3.
- Streaming: push 8'h01..8'h10 back-to-back with `out_ready` = 1 → the same sequence appears one cycle later with no gaps, and `bubble_cnt` does not change.
- Back-pressure (SKID = 1): stream 8'h01, 8'h02, 8'h03, and drop `out_ready` at the cycle 8'h01 is presented → 8'h02 is held in skid and `in_ready` goes 0. When `out_ready` returns, the output is 8'h01, 8'h02, 8'h03 in order.
- Flush with full buffer: in state TWO (8'h05, 8'h06), assert `flush` together with `in_valid` and 8'h07 → the next cycle has `out_valid` 0 and `out_data` 8'hAA, and 8'h07 never appears.
- SKID = 0 combinational ready: with `out_valid` = 1, toggle `out_ready` 1/0 → `in_ready` follows `out_ready` in the same cycle, and no data is lost or duplicated.
- Saturation: CNT_W = 3, starve for 10 cycles → `bubble_cnt` holds 7. Then assert `rst` → 0.
